// File: rtl/dc_wb_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and the block memory port.
// Define DC_STATS_EN to add the hit/miss/write-back statistics counters.
module dc_wb_cache #(
    parameter int NUM_LINES   = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              write_data,
    input  logic [1:0]               write_size,
    output logic [31:0]              read_data,
    output logic                     data_valid,
    input  logic                     flush,
    output logic                     flush_done,
    output logic [ADDR_W-1:0]        blk_addr,
    output logic                     blk_read,
    output logic                     blk_write,
    input  logic [32*BLOCK_WORDS-1:0] blk_read_data,
    output logic [32*BLOCK_WORDS-1:0] blk_write_data,
    input  logic                     blk_read_valid,
    input  logic                     blk_write_valid
`ifdef DC_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count,
    output logic [31:0]              wb_count
`endif
);

    localparam int OFF_W  = $clog2(4 * BLOCK_WORDS);
    localparam int WSEL_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(NUM_LINES - 1);

    // Word 0 sits in the top 32 bits, so word w lives at element BLOCK_WORDS-1-w (= ~w).
    typedef logic [BLOCK_WORDS-1:0][31:0] line_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL,
        S_FLUSH_SCAN,
        S_FLUSH_WB,
        S_FLUSH_DONE
    } state_t;

    state_t             r_state;
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]   r_tag [NUM_LINES];
    line_t              r_data [NUM_LINES];
    logic [IDX_W-1:0]   r_line;
    logic [TAG_W-1:0]   r_req_tag;
    logic               r_blk_read;
    logic               r_blk_write;
    logic               r_flush_done;
    logic [ADDR_W-1:0]  r_blk_addr;

    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_idx;
    logic [WSEL_W-1:0]  w_wsel;
    logic [1:0]         w_lane;
    line_t              w_line;
    logic [31:0]        w_word;
    logic [31:0]        w_merged;
    logic [2:0]         w_size;
    logic               w_req;
    logic               w_hit;
    logic               w_miss;
    logic               w_wr_hit;

    assign w_tag  = addr[ADDR_W-1 -: TAG_W];
    assign w_idx  = addr[OFF_W +: IDX_W];
    assign w_wsel = addr[2 +: WSEL_W];
    assign w_lane = addr[1:0];

    assign w_line = r_data[w_idx];
    assign w_word = w_line[~w_wsel];

    assign w_req    = read | write;
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss   = (r_state == S_IDLE) && !flush && w_req && !w_hit;
    assign w_wr_hit = (r_state == S_IDLE) && !flush && write && w_hit;

    assign read_data      = w_word;
    assign blk_read       = r_blk_read;
    assign blk_write      = r_blk_write;
    assign blk_addr       = r_blk_addr;
    assign flush_done     = r_flush_done;
    assign blk_write_data = r_data[r_line];

    // Byte-lane merge: lane 0 is the most significant byte; lanes past 3 fall off the word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_size   = (write_size == 2'd0) ? 3'd4 : {1'b0, write_size};
        w_merged = w_word;
        for (int k = 0; k < 4; k++) begin
            if ((3'(k) >= {1'b0, w_lane}) && (3'(k) < ({1'b0, w_lane} + w_size))) begin
                w_merged[31-8*k -: 8] = write_data[31-8*k -: 8];
            end
        end
    end

    always_comb begin
        data_valid = 1'b0;
        if (r_state == S_IDLE) begin
            data_valid = !w_req || (w_hit && !flush);
        end
    end

    // NOTE: tag and data arrays carry no reset; the cleared valid bits make their contents irrelevant.
    always_ff @(posedge CLK) begin
        if ((r_state == S_REFILL) && blk_read_valid) begin
            r_data[r_line] <= blk_read_data;
            r_tag[r_line]  <= r_req_tag;
        end else if (w_wr_hit) begin
            r_data[w_idx][~w_wsel] <= w_merged;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_line       <= '0;
            r_req_tag    <= '0;
            r_blk_read   <= 1'b0;
            r_blk_write  <= 1'b0;
            r_flush_done <= 1'b0;
            r_blk_addr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_state <= S_FLUSH_SCAN;
                        r_line  <= '0;
                    end else if (w_miss) begin
                        r_line    <= w_idx;
                        r_req_tag <= w_tag;
                        if (r_dirty[w_idx]) begin
                            r_state     <= S_WRITEBACK;
                            r_blk_write <= 1'b1;
                            r_blk_addr  <= {r_tag[w_idx], w_idx, {OFF_W{1'b0}}};
                        end else begin
                            r_state    <= S_REFILL;
                            r_blk_read <= 1'b1;
                            r_blk_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
                        end
                    end else if (w_wr_hit) begin
                        r_dirty[w_idx] <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (blk_write_valid) begin
                        r_dirty[r_line] <= 1'b0;
                        r_blk_write     <= 1'b0;
                        r_blk_read      <= 1'b1;
                        r_blk_addr      <= {r_req_tag, r_line, {OFF_W{1'b0}}};
                        r_state         <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (blk_read_valid) begin
                        r_valid[r_line] <= 1'b1;
                        r_dirty[r_line] <= 1'b0;
                        r_blk_read      <= 1'b0;
                        r_state         <= S_IDLE;
                    end
                end
                S_FLUSH_SCAN: begin
                    if (r_dirty[r_line]) begin
                        r_state     <= S_FLUSH_WB;
                        r_blk_write <= 1'b1;
                        r_blk_addr  <= {r_tag[r_line], r_line, {OFF_W{1'b0}}};
                    end else begin
                        r_valid[r_line] <= 1'b0;
                        if (r_line == LAST_LINE) begin
                            r_state      <= S_FLUSH_DONE;
                            r_flush_done <= 1'b1;
                        end else begin
                            r_line <= r_line + 1'b1;
                        end
                    end
                end
                S_FLUSH_WB: begin
                    if (blk_write_valid) begin
                        r_blk_write     <= 1'b0;
                        r_dirty[r_line] <= 1'b0;
                        r_valid[r_line] <= 1'b0;
                        if (r_line == LAST_LINE) begin
                            r_state      <= S_FLUSH_DONE;
                            r_flush_done <= 1'b1;
                        end else begin
                            r_line  <= r_line + 1'b1;
                            r_state <= S_FLUSH_SCAN;
                        end
                    end
                end
                S_FLUSH_DONE: begin
                    if (!flush) begin
                        r_state      <= S_IDLE;
                        r_flush_done <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DC_STATS_EN
    logic        r_retry;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic [31:0] r_wb_count;
    logic        w_hit_evt;
    logic        w_wb_evt;

    // A request re-evaluated after its own refill is not a first-cycle hit.
    assign w_hit_evt = (r_state == S_IDLE) && !flush && w_req && w_hit && !r_retry;
    assign w_wb_evt  = ((r_state == S_WRITEBACK) || (r_state == S_FLUSH_WB)) && blk_write_valid;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_retry      <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            if (w_hit_evt) r_hit_count  <= r_hit_count + 32'd1;
            if (w_miss)    r_miss_count <= r_miss_count + 32'd1;
            if (w_wb_evt)  r_wb_count   <= r_wb_count + 32'd1;
            if (w_miss) begin
                r_retry <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_retry <= 1'b0;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
    assign wb_count   = r_wb_count;
`endif

endmodule

// File: tb/tb_dc_wb_cache.sv
// Directed bench for dc_wb_cache: cold refill, byte stores, dirty eviction, flush and mid-refill reset.
// Memory words are generated as (byte address ^ 0xC0DE0000) so expected values are computed by hand.
module tb_dc_wb_cache;

    logic         CLK;
    logic         RESET;
    logic [31:0]  addr;
    logic         read;
    logic         write;
    logic [31:0]  write_data;
    logic [1:0]   write_size;
    logic [31:0]  read_data;
    logic         data_valid;
    logic         flush;
    logic         flush_done;
    logic [31:0]  blk_addr;
    logic         blk_read;
    logic         blk_write;
    logic [255:0] blk_read_data;
    logic [255:0] blk_write_data;
    logic         blk_read_valid;
    logic         blk_write_valid;
`ifdef DC_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
    logic [31:0]  wb_count;
`endif

    int n_checks  = 0;
    int n_fail    = 0;
    int n_overlap = 0;

    dc_wb_cache #(.NUM_LINES(16), .BLOCK_WORDS(8), .ADDR_W(32)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .addr           (addr),
        .read           (read),
        .write          (write),
        .write_data     (write_data),
        .write_size     (write_size),
        .read_data      (read_data),
        .data_valid     (data_valid),
        .flush          (flush),
        .flush_done     (flush_done),
        .blk_addr       (blk_addr),
        .blk_read       (blk_read),
        .blk_write      (blk_write),
        .blk_read_data  (blk_read_data),
        .blk_write_data (blk_write_data),
        .blk_read_valid (blk_read_valid),
        .blk_write_valid(blk_write_valid)
`ifdef DC_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count),
        .wb_count       (wb_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (blk_read && blk_write) n_overlap++;
    end

    function automatic logic [255:0] make_block(input logic [31:0] base);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) begin
            b[(7-w)*32 +: 32] = (base + 32'(4*w)) ^ 32'hC0DE_0000;
        end
        return b;
    endfunction

    function automatic logic [31:0] word_of(input logic [255:0] b, input int w);
        return b[(7-w)*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Answers one block read after lat cycles of blk_read, checking the requested address.
    task automatic serve_read(input logic [31:0] exp_addr, input int lat);
        for (int c = 0; c < 20 && !blk_read; c++) tick();
        chk("refill_req", 32'(blk_read), 32'd1);
        chk("refill_addr", blk_addr, exp_addr);
        chk("refill_no_write", 32'(blk_write), 32'd0);
        repeat (lat - 1) tick();
        blk_read_valid = 1'b1;
        blk_read_data  = make_block(exp_addr);
        tick();
        blk_read_valid = 1'b0;
        blk_read_data  = '0;
        settle();
    endtask

    task automatic write_miss(input logic [31:0] a, input logic [31:0] d);
        addr       = a;
        write      = 1'b1;
        write_size = 2'd0;
        write_data = d;
        settle();
        chk("wmiss_dv", 32'(data_valid), 32'd0);
        tick();
        serve_read({a[31:5], 5'b0}, 2);
        chk("wmiss_hit_dv", 32'(data_valid), 32'd1);
        tick();
        write = 1'b0;
        settle();
    endtask

    logic [31:0] wb_addr [3];
    logic [31:0] wb_w0 [3];
    int n_wb;

    initial begin
        RESET = 1'b1; addr = '0; read = 1'b0; write = 1'b0; write_data = '0; write_size = 2'd0;
        flush = 1'b0; blk_read_data = '0; blk_read_valid = 1'b0; blk_write_valid = 1'b0;
        n_wb = 0;
        #1 RESET = 1'b0;
        #2;
        chk("rst_data_valid", 32'(data_valid), 32'd1);
        chk("rst_blk_read", 32'(blk_read), 32'd0);
        chk("rst_blk_write", 32'(blk_write), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_blk_addr", blk_addr, 32'h0);
        read = 1'b1;
        settle();
        chk("rst_dv_with_req", 32'(data_valid), 32'd0);
        read = 1'b0;
        tick();
        tick();
        RESET = 1'b1;

        // Cold read, memory answers 3 cycles after blk_read.
        addr = 32'h1000_0004;
        read = 1'b1;
        settle();
        chk("cold_miss_dv", 32'(data_valid), 32'd0);
        tick();
        chk("refill_dv", 32'(data_valid), 32'd0);
        serve_read(32'h1000_0000, 3);
        chk("cold_dv", 32'(data_valid), 32'd1);
        chk("cold_data", read_data, 32'hD0DE_0004);
        chk("cold_blk_read_drop", 32'(blk_read), 32'd0);
        tick();
        chk("hit_dv", 32'(data_valid), 32'd1);
        chk("hit_data", read_data, 32'hD0DE_0004);
        addr = 32'h1000_001C;
        settle();
        chk("hit_word7", read_data, 32'hD0DE_001C);

        // Byte, truncated and full-word stores into the resident line.
        read = 1'b0; write = 1'b1;
        addr = 32'h1000_0006; write_size = 2'd1; write_data = 32'h0000_AB00;
        settle();
        chk("wr_hit_dv", 32'(data_valid), 32'd1);
        tick();
        addr = 32'h1000_000B; write_size = 2'd3; write_data = 32'h1122_3344;
        tick();
        addr = 32'h1000_000C; write_size = 2'd0; write_data = 32'hCAFE_BABE;
        tick();
        write = 1'b0; read = 1'b1;
        addr = 32'h1000_0004;
        settle();
        chk("byte_store", read_data, 32'hD0DE_AB04);
        addr = 32'h1000_0008;
        settle();
        chk("lane_drop", read_data, 32'hD0DE_0044);
        addr = 32'h1000_000C;
        settle();
        chk("word_store", read_data, 32'hCAFE_BABE);

        // Conflict miss on the dirty line: write-back first, then refill.
        addr = 32'h1000_0200;
        settle();
        chk("conf_miss_dv", 32'(data_valid), 32'd0);
        tick();
        chk("wb_blk_write", 32'(blk_write), 32'd1);
        chk("wb_no_read", 32'(blk_read), 32'd0);
        chk("wb_addr", blk_addr, 32'h1000_0000);
        chk("wb_word0", word_of(blk_write_data, 0), 32'hD0DE_0000);
        chk("wb_word1", word_of(blk_write_data, 1), 32'hD0DE_AB04);
        chk("wb_word3", word_of(blk_write_data, 3), 32'hCAFE_BABE);
        tick();
        chk("wb_hold", 32'(blk_write), 32'd1);
        blk_write_valid = 1'b1;
        tick();
        blk_write_valid = 1'b0;
        settle();
        chk("wb_release", 32'(blk_write), 32'd0);
        serve_read(32'h1000_0200, 1);
        chk("conf_dv", 32'(data_valid), 32'd1);
        chk("conf_data", read_data, 32'hD0DE_0200);

        // Stray completion strobes in IDLE must not touch the line.
        read = 1'b0;
        blk_read_valid = 1'b1; blk_write_valid = 1'b1; blk_read_data = '1;
        tick();
        blk_read_valid = 1'b0; blk_write_valid = 1'b0; blk_read_data = '0;
        read = 1'b1;
        settle();
        chk("stray_ignored", read_data, 32'hD0DE_0200);
        read = 1'b0;

        // Three dirty lines (indices 1, 5, 15), then flush.
        write_miss(32'h2000_0020, 32'h1111_0001);
        write_miss(32'h2000_00A0, 32'h5555_0005);
        write_miss(32'h2000_01E0, 32'hFFFF_000F);
        flush = 1'b1;
        tick();
        chk("flush_dv", 32'(data_valid), 32'd0);
        for (int c = 0; c < 200 && !flush_done; c++) begin
            if (blk_write) begin
                chk("done_after_wb", 32'(flush_done), 32'd0);
                if (n_wb < 3) begin
                    wb_addr[n_wb] = blk_addr;
                    wb_w0[n_wb]   = word_of(blk_write_data, 0);
                end
                n_wb++;
                blk_write_valid = 1'b1;
                tick();
                blk_write_valid = 1'b0;
            end else begin
                tick();
            end
        end
        chk("flush_done", 32'(flush_done), 32'd1);
        chk("flush_wb_count", 32'(n_wb), 32'd3);
        chk("flush_addr0", wb_addr[0], 32'h2000_0020);
        chk("flush_addr1", wb_addr[1], 32'h2000_00A0);
        chk("flush_addr2", wb_addr[2], 32'h2000_01E0);
        chk("flush_data0", wb_w0[0], 32'h1111_0001);
        chk("flush_data1", wb_w0[1], 32'h5555_0005);
        chk("flush_data2", wb_w0[2], 32'hFFFF_000F);
        tick();
        chk("flush_done_hold", 32'(flush_done), 32'd1);
        flush = 1'b0;
        tick();
        chk("flush_done_low", 32'(flush_done), 32'd0);

        // Everything misses after the flush.
        read = 1'b1;
        addr = 32'h2000_0020;
        settle();
        chk("post_flush_miss_a", 32'(data_valid), 32'd0);
        addr = 32'h1000_0200;
        settle();
        chk("post_flush_miss_b", 32'(data_valid), 32'd0);
        tick();
        chk("pf_blk_read", 32'(blk_read), 32'd1);
        chk("pf_no_write", 32'(blk_write), 32'd0);
        chk("pf_addr", blk_addr, 32'h1000_0200);

        // Reset in the middle of the refill drops blk_read without a clock edge.
        #2;
        RESET = 1'b0;
        settle();
        chk("rst_mid_blk_read", 32'(blk_read), 32'd0);
        chk("rst_mid_dv", 32'(data_valid), 32'd0);
        tick();
        RESET = 1'b1;
        settle();
        chk("rst_again_miss", 32'(data_valid), 32'd0);
        tick();
        serve_read(32'h1000_0200, 2);
        chk("rst_refill_dv", 32'(data_valid), 32'd1);
        chk("rst_refill_data", read_data, 32'hD0DE_0200);

`ifdef DC_STATS_EN
        read = 1'b0;
        settle();
        force dut.r_miss_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_miss_count;
        addr = 32'h3000_0000;
        read = 1'b1;
        settle();
        tick();
        chk("miss_wrap", miss_count, 32'h0);
        serve_read(32'h3000_0000, 1);
`endif

        read = 1'b0;
        settle();
        chk("no_overlap", 32'(n_overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dc_wb_cache.md
Name: dc_wb_cache

Overview:
- Parametrised, direct-mapped, write-back, write-allocate data cache.
- Sits between the MEM stage's data request port and the main-memory block interface, replacing the current pass-through data path.
- Reports `data_valid=0` while it services a miss. The pipeline freezes on that signal, the same way it freezes on the instruction-cache stall.
- Supports a full flush-and-invalidate before a syscall.

Parameters:
- `NUM_LINES`, 16, number of cache lines; power of two, at least 2.
- `BLOCK_WORDS`, 8, 32-bit words per line; power of two, at least 2. Block width is `32*BLOCK_WORDS`.
- `ADDR_W`, 32, byte address width.

Ports:
- `CLK` in 1: the only clock.
- `RESET` in 1: reset, asynchronous, active-low.
- `addr` in `ADDR_W`: byte address of the request.
- `read` in 1: load request.
- `write` in 1: store request.
- `write_data` in 32: store bytes, already placed in their word lanes.
- `write_size` in 2: bytes to write; 1/2/3 = that many bytes, 0 = 4 bytes.
- `read_data` out 32: word containing `addr`.
- `data_valid` out 1: request completed in this cycle.
- `flush` in 1: request write-back of all dirty lines and invalidation of all lines.
- `flush_done` out 1: flush complete.
- `blk_addr` out `ADDR_W`: block-aligned memory address.
- `blk_read` out 1: block read request.
- `blk_write` out 1: block write request.
- `blk_read_data` in `32*BLOCK_WORDS`: refill data.
- `blk_write_data` out `32*BLOCK_WORDS`: victim data.
- `blk_read_valid` in 1: block read has completed.
- `blk_write_valid` in 1: block write has completed.

Behaviour:
- Address split: offset is `log2(4*BLOCK_WORDS)` bits, index is `log2(NUM_LINES)` bits, tag is the remainder.
  - Word 0 of a block occupies the most significant 32 bits of the block bus.
  - Byte lane 0 is bits 31:24 (big-endian).
- Reset (asynchronous, `RESET=0`):
  - All valid and dirty bits are cleared; state is IDLE.
  - `blk_read=0`, `blk_write=0`, `flush_done=0`, `blk_addr=0`.
  - `data_valid` = 1 when neither `read` nor `write` is asserted, otherwise 0.
  - A reset in the middle of a transaction abandons it, and no line is written.
- IDLE:
  - Hit = valid bit set and tag equal.
  - With no request, `data_valid=1`.
  - Read hit: `read_data` and `data_valid=1` are combinational in the same cycle.
  - Write hit: `data_valid=1` in the same cycle. At the clock edge, lanes `addr[1:0]` through `addr[1:0]+N-1` are updated (lanes past lane 3 are dropped) and the dirty bit is set.
  - Miss on a clean or invalid line: `data_valid=0`, next state REFILL.
  - Miss on a dirty line: `data_valid=0`, next state WRITEBACK.
  - When `read` and `write` are both asserted, the request is treated as a write.
  - `flush` takes priority over `read` and `write`; next state FLUSH_SCAN.
- WRITEBACK:
  - `blk_write=1`, `blk_addr` = {victim tag, index, 0}, `blk_write_data` = victim line.
  - Outputs are held until a cycle with `blk_write_valid=1`. The dirty bit is then cleared and the next state is REFILL.
- REFILL:
  - `blk_read=1`, `blk_addr` = {request tag, index, 0}.
  - On `blk_read_valid=1` the line is loaded, its valid bit set, its dirty bit cleared, and the next state is IDLE.
  - The request is re-evaluated in IDLE and hits, so miss latency is at least 2 cycles beyond the memory latency.
- Request hold rule: the requester holds `addr`, `read`, `write`, `write_data` and `write_size` stable while `data_valid=0`. If it drops the request mid-miss, the refill still completes.
- FLUSH_SCAN:
  - A line counter `i` starts at 0.
  - If line `i` is dirty, next state is FLUSH_WB: `blk_write` asserts for line `i` and is held until `blk_write_valid`.
  - Line `i` is then invalidated and `i` incremented.
  - After line `NUM_LINES-1` the next state is FLUSH_DONE. A clean or invalid line costs 1 cycle.
- FLUSH_DONE:
  - `flush_done=1` while `flush` remains high; IDLE when `flush` falls.
  - `data_valid=0` during every flush state.
- `blk_read` and `blk_write` are never asserted together.
- Completion strobes arriving in a state that is not waiting for them are ignored.

Optional Feature:
- Macro `DC_STATS_EN`.
- When defined, three extra outputs are present: `hit_count`, `miss_count` and `wb_count`, each 32 bits and cleared by reset.
  - `hit_count` increments once per request that hits on its first IDLE cycle.
  - `miss_count` increments once per miss entry.
  - `wb_count` increments per completed block write, flush included.
  - All three wrap from `0xFFFFFFFF` to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold read at `0x1000_0004` with `blk_read_valid` 3 cycles after `blk_read` → `blk_addr=0x1000_0000`. After refill, `read_data` = word 1 of the block and `data_valid=1`; a second read of the same address hits in the same cycle.
- Byte store, `write_size=1`, `addr=0x1000_0006`, `write_data=0x0000AB00` → lane 2 only is updated. A subsequent read returns the old word with bits 15:8 = `0xAB`, and the line is dirty.
- Read of `0x1000_0000 + 4*BLOCK_WORDS*NUM_LINES`, which conflicts with the dirty line → `blk_write` of the old block at `0x1000_0000` first, then `blk_read` of the new block; never both high together.
- Flush with 3 dirty lines out of 16 → exactly 3 block writes at the correct addresses. `flush_done` rises only after them, and every following access misses.
- `RESET` driven low while `blk_read=1` → `blk_read=0` immediately, without a clock edge; after release the original address misses again.
- With `DC_STATS_EN`, preset `miss_count` to `0xFFFFFFFF` and cause a miss → the counter wraps to 0.
